programmable_clock_divider: RTL and testbench

//  Parametrised, runtime-programmable successor of the fixed divide-by-100 tick generator.

---
 rtl/programmable_clock_divider.sv | 105 ++++++++++
 tb/tb_programmable_clock_divider.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/programmable_clock_divider.sv
// Runtime-programmable clock divider: one-cycle tick every N enabled cycles, near-50% square
// wave, pause, and reprogramming that waits for the current period to finish.
module programmable_clock_divider #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEFAULT_DIV = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             tick,
  output logic             sq_out,
  output logic [WIDTH-1:0] count,
  output logic             load_busy,
  output logic             load_err
);

  typedef enum logic [0:0] {StIdle, StPend} pend_state_e;

  localparam logic [WIDTH-1:0] DefaultDiv = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] One        = WIDTH'(1);

  pend_state_e      state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             load_ok;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH:0]   half;

  assign wrap    = en && (cnt_q == (div_q - One));
  assign load_ok = div_load && (div_in != '0);
  // One extra bit so div_q = 2^WIDTH-1 cannot overflow the rounding add.
  assign half    = ((WIDTH+1)'(div_q) + (WIDTH+1)'(1)) >> 1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    pend_d   = pend_q;
    sq_d     = sq_q;
    tick_d   = wrap;
    err_d    = div_load && (div_in == '0);
    cnt_next = wrap ? '0 : cnt_q + One;

    if (!en) begin
      // Paused: a valid load takes effect immediately and restarts the period.
      if (load_ok) begin
        div_d   = div_in;
        cnt_d   = '0;
        state_d = StIdle;
      end
    end else begin
      cnt_d = cnt_next;
      sq_d  = ({1'b0, cnt_next} < half);
      if (wrap) begin
        state_d = StIdle;
        if (load_ok) begin
          div_d = div_in;
        end else begin
          unique case (state_q)
            StPend:  div_d = pend_q;
            default: div_d = div_q;
          endcase
        end
      end else if (load_ok) begin
        pend_d  = div_in;
        state_d = StPend;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= DefaultDiv;
      pend_q  <= '0;
      tick_q  <= 1'b0;
      sq_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      sq_q    <= sq_d;
      err_q   <= err_d;
    end
  end

  assign tick      = tick_q;
  assign sq_out    = sq_q;
  assign count     = cnt_q;
  assign load_busy = (state_q == StPend);
  assign load_err  = err_q;

endmodule

// File: tb/tb_programmable_clock_divider.sv
// Bench for programmable_clock_divider: directed scenarios with fixed expectations plus a
// randomized run checked against an arithmetic reference model.
module tb_programmable_clock_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_in = '0;
  logic        div_load = 1'b0;
  logic        tick;
  logic        sq_out;
  logic [15:0] count;
  logic        load_busy;
  logic        load_err;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int m_cnt = 0;
  int m_div = 100;
  int m_pend = 0;
  bit m_busy = 0;
  bit m_tick = 0;
  bit m_sq = 0;
  bit m_err = 0;

  programmable_clock_divider #(
    .WIDTH      (16),
    .DEFAULT_DIV(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .tick     (tick),
    .sq_out   (sq_out),
    .count    (count),
    .load_busy(load_busy),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  // Apply one clock with the given inputs, then advance the model by one cycle.
  task automatic step(input bit r, input bit e, input bit l, input int d);
    bit wrap;
    bit acc;
    rst = r;
    en = e;
    div_load = l;
    div_in = 16'(d);
    @(posedge clk);
    #1;
    if (r) begin
      m_cnt = 0; m_div = 100; m_busy = 0; m_tick = 0; m_sq = 0; m_err = 0;
    end else begin
      wrap = e && (m_cnt == m_div - 1);
      acc = l && (d != 0);
      m_err = l && (d == 0);
      m_tick = wrap;
      if (!e) begin
        if (acc) begin
          m_div = d; m_cnt = 0; m_busy = 0;
        end
      end else begin
        m_cnt = (m_cnt + 1) % m_div;
        m_sq = m_cnt < (m_div + 1) / 2;
        if (wrap) begin
          if (acc) m_div = d;
          else if (m_busy) m_div = m_pend;
          m_busy = 0;
        end else if (acc) begin
          m_pend = d; m_busy = 1;
        end
      end
    end
  endtask

  task automatic test_reset;
    // en and a zero load are active during reset; reset must override both.
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    n_total++;
    if (tick !== 1'b0) $display("FAIL reset_tick: got %0b want 0", tick); else n_pass++;
    n_total++;
    if (sq_out !== 1'b0) $display("FAIL reset_sq: got %0b want 0", sq_out); else n_pass++;
    n_total++;
    if (count !== 16'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_total++;
    if (load_busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", load_busy); else n_pass++;
    n_total++;
    if (load_err !== 1'b0) $display("FAIL reset_err: got %0b want 0", load_err); else n_pass++;
  endtask

  task automatic test_default_period;
    step(1, 0, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      step(0, 1, 0, 0);
      n_total++;
      if (tick !== (k % 100 == 0))
        $display("FAIL default_tick k=%0d: got %0b want %0b", k, tick, (k % 100 == 0));
      else n_pass++;
      n_total++;
      if (count !== 16'(k % 100))
        $display("FAIL default_count k=%0d: got %0d want %0d", k, count, k % 100);
      else n_pass++;
    end
  endtask

  task automatic test_load_idle;
    step(1, 0, 0, 0);
    step(0, 0, 1, 5);
    n_total++;
    if (count !== 16'd0 || sq_out !== 1'b0 || load_busy !== 1'b0)
      $display("FAIL idle_load: got cnt=%0d sq=%0b busy=%0b want 0 0 0", count, sq_out, load_busy);
    else n_pass++;
    for (int k = 1; k <= 15; k++) begin
      step(0, 1, 0, 0);
      n_total++;
      if (tick !== (k % 5 == 0) || sq_out !== ((k % 5) < 3) || count !== 16'(k % 5))
        $display("FAIL div5 k=%0d: got t=%0b sq=%0b c=%0d want %0b %0b %0d", k, tick, sq_out,
                 count, (k % 5 == 0), ((k % 5) < 3), k % 5);
      else n_pass++;
    end
  endtask

  task automatic test_pending_load;
    bit exp_tick;
    int exp_cnt;
    step(1, 0, 0, 0);
    repeat (40) step(0, 1, 0, 0);
    n_total++;
    if (count !== 16'd40) $display("FAIL pend_pre_count: got %0d want 40", count); else n_pass++;
    for (int k = 41; k <= 130; k++) begin
      step(0, 1, (k == 41), 10);
      exp_tick = (k == 100) || (k > 100 && (k - 100) % 10 == 0);
      exp_cnt = (k < 100) ? k : (k - 100) % 10;
      n_total++;
      if (load_busy !== (k < 100) || tick !== exp_tick || count !== 16'(exp_cnt))
        $display("FAIL pending k=%0d: got b=%0b t=%0b c=%0d want %0b %0b %0d", k, load_busy,
                 tick, count, (k < 100), exp_tick, exp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_pause;
    step(1, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0);
    for (int k = 21; k <= 27; k++) begin
      step(0, 0, 0, 0);
      n_total++;
      if (count !== 16'd20 || tick !== 1'b0)
        $display("FAIL pause_hold k=%0d: got c=%0d t=%0b want 20 0", k, count, tick);
      else n_pass++;
    end
    for (int k = 28; k <= 107; k++) begin
      step(0, 1, 0, 0);
      n_total++;
      if (tick !== (k == 107) || count !== 16'((k - 7) % 100))
        $display("FAIL pause_resume k=%0d: got t=%0b c=%0d want %0b %0d", k, tick, count,
                 (k == 107), (k - 7) % 100);
      else n_pass++;
    end
  endtask

  task automatic test_zero_and_one;
    step(1, 0, 0, 0);
    repeat (10) step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    n_total++;
    if (load_err !== 1'b1 || load_busy !== 1'b0 || count !== 16'd11)
      $display("FAIL zero_load: got e=%0b b=%0b c=%0d want 1 0 11", load_err, load_busy, count);
    else n_pass++;
    step(0, 1, 0, 0);
    n_total++;
    if (load_err !== 1'b0) $display("FAIL zero_err_width: got %0b want 0", load_err); else n_pass++;
    for (int k = 13; k <= 100; k++) begin
      step(0, 1, 0, 0);
      n_total++;
      if (tick !== (k == 100))
        $display("FAIL zero_period k=%0d: got %0b want %0b", k, tick, (k == 100));
      else n_pass++;
    end
    step(0, 0, 1, 1);
    for (int k = 1; k <= 5; k++) begin
      step(0, 1, 0, 0);
      n_total++;
      if (tick !== 1'b1 || sq_out !== 1'b1 || count !== 16'd0)
        $display("FAIL div1 k=%0d: got t=%0b sq=%0b c=%0d want 1 1 0", k, tick, sq_out, count);
      else n_pass++;
    end
  endtask

  task automatic test_reset_pending;
    step(1, 0, 0, 0);
    repeat (60) step(0, 1, 0, 0);
    step(0, 1, 1, 7);
    n_total++;
    if (load_busy !== 1'b1) $display("FAIL rp_busy: got %0b want 1", load_busy); else n_pass++;
    step(1, 1, 0, 0);
    n_total++;
    if (count !== 16'd0 || tick !== 1'b0 || load_busy !== 1'b0)
      $display("FAIL rp_reset: got c=%0d t=%0b b=%0b want 0 0 0", count, tick, load_busy);
    else n_pass++;
    for (int k = 1; k <= 100; k++) begin
      step(0, 1, 0, 0);
      n_total++;
      if (tick !== (k == 100))
        $display("FAIL rp_period k=%0d: got %0b want %0b", k, tick, (k == 100));
      else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [19:0] got;
    logic [19:0] want;
    bit r, e, l;
    int d;
    step(1, 0, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(199, 0) == 0);
      e = ($urandom_range(9, 0) < 8);
      l = ($urandom_range(19, 0) == 0);
      d = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(12, 1));
      step(r, e, l, d);
      got = {tick, sq_out, count, load_busy, load_err};
      want = {m_tick, m_sq, 16'(m_cnt), m_busy, m_err};
      n_total++;
      if (got !== want)
        $display("FAIL random k=%0d: got t/sq/c/b/e=%05h want %05h", k, got, want);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_default_period();
    test_load_idle();
    test_pending_load();
    test_pause();
    test_zero_and_one();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
